// File: rtl/inst_sram_resp_if.sv
// -----------------------------------------------------------------------------
// inst_sram_resp_if
//
// Purpose : fetch-stage instruction SRAM bus. Bundles the request fields the
//           core drives and the response fields the memory returns.
//
// Signals :
//   en       - access enable for this cycle
//   we[3:0]  - byte write enables, 0 = read
//   addr     - byte address, bits [1:0] ignored by the memory
//   wdata    - write data, byte lanes selected by we
//   rdata    - registered read data (memory -> core)
//   addr_err - registered: previous enabled access fell outside the window
//
// Modports:
//   master - the fetch stage (initiator)
//   slave  - the memory responder
// -----------------------------------------------------------------------------
interface inst_sram_resp_if;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_err;

  modport master (
    output en,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  addr_err
  );

  modport slave (
    input  en,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output addr_err
  );
endinterface

// File: rtl/inst_sram_resp.sv
// -----------------------------------------------------------------------------
// inst_sram_resp
//
// Purpose : single-port instruction memory answering the fetch stage. The
//           word addressed in cycle N appears on rdata in cycle N+1 and stays
//           there while en is low, so the fetch stage can stall a PC in place.
//           Byte-masked writes are read-first. Accesses outside the window
//           [BASE_ADDR, BASE_ADDR + 4*2^ADDR_WIDTH) return 0 and flag addr_err.
//
// Parameters:
//   ADDR_WIDTH - word-index width, depth = 2^ADDR_WIDTH words (<= 29)
//   BASE_ADDR  - byte address of word 0, 4-byte aligned
//   FILL_WORD  - value written by the clear sweep (LoongArch nop)
//
// Ports:
//   clk       in  - the only clock
//   resetn    in  - synchronous, active-low reset
//   bus       slave modport of inst_sram_resp_if (en/we/addr/wdata in,
//                   rdata/addr_err out)
//   mem_ready out - registered, high once the memory is in RUN
//
// Build option:
//   INST_SRAM_CLEAR_EN - when defined, reset enters a CLEAR state that writes
//   FILL_WORD to every word (one word per cycle) before going to RUN. When not
//   defined, the block is in RUN straight out of reset and mem_ready is high.
// -----------------------------------------------------------------------------
module inst_sram_resp #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h1c00_0000,
  parameter logic [31:0] FILL_WORD  = 32'h0340_0000
) (
  input  logic              clk,
  input  logic              resetn,
  inst_sram_resp_if.slave   bus,
  output logic              mem_ready
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned SPAN_BITS = ADDR_WIDTH + 2;

  // Source of the value presented on rdata. Keeping the raw RAM read in its
  // own register (no reset, no mux in front) lets the array map onto block
  // RAM; the zero / fill substitution happens after that register.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_FILL = 2'd2
  } rd_src_t;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]           offset;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  unused_addr_lsbs;

  // Wrapping subtraction: addresses below BASE_ADDR become huge offsets and
  // fall out of range through the same test as addresses above the window.
  assign offset           = bus.addr - BASE_ADDR;
  assign in_range         = (offset[31:SPAN_BITS] == '0);
  assign idx              = offset[SPAN_BITS-1:2];
  assign unused_addr_lsbs = ^offset[1:0];

  // ---------------------------------------------------------------------------
  // Storage and registered state
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_rd_q;
  rd_src_t     src_q;
  logic        addr_err_q;
  logic        mem_ready_q;
  logic        clearing;

`ifdef INST_SRAM_CLEAR_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;

  assign clearing = (state_q == ST_CLEAR);
`else
  assign clearing = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Write port: the clear sweep owns it while clearing, otherwise in-range
  // enabled accesses write the lanes selected by we. Nothing is written while
  // reset is held, so a reset never corrupts contents.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_be;

  always_comb begin
    wr_addr = idx;
    wr_data = bus.wdata;
    wr_be   = 4'b0000;
    if (resetn) begin
      if (clearing) begin
`ifdef INST_SRAM_CLEAR_EN
        wr_addr = clr_cnt_q;
`endif
        wr_data = FILL_WORD;
        wr_be   = 4'b1111;
      end else if (bus.en && in_range) begin
        wr_be = bus.we;
      end
    end
  end

  // Per-lane write enables laid out lane by lane.
  logic [3:0] lane_we;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = wr_be[gi];
    end
  endgenerate

  // RAM array: read-first, because the read register samples the array
  // contents before this edge's non-blocking writes land.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (bus.en) begin
      mem_rd_q <= mem_q[idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Control: response source, error flag, clear sweep and ready flag.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      src_q      <= SRC_ZERO;
      addr_err_q <= 1'b0;
`ifdef INST_SRAM_CLEAR_EN
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      mem_ready_q <= 1'b0;
`else
      mem_ready_q <= 1'b1;
`endif
    end else begin
      if (bus.en) begin
        if (clearing) begin
          // Sweep in progress: answer with the fill value, drop the write.
          src_q      <= SRC_FILL;
          addr_err_q <= 1'b0;
        end else if (in_range) begin
          src_q      <= SRC_MEM;
          addr_err_q <= 1'b0;
        end else begin
          src_q      <= SRC_ZERO;
          addr_err_q <= 1'b1;
        end
      end
`ifdef INST_SRAM_CLEAR_EN
      if (state_q == ST_CLEAR) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
        // Leave CLEAR on the edge that writes the last word, so mem_ready is
        // seen high exactly 2^ADDR_WIDTH cycles after reset release.
        if (&clr_cnt_q) begin
          state_q     <= ST_RUN;
          mem_ready_q <= 1'b1;
        end
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [31:0] rdata_mux;

  always_comb begin
    rdata_mux = '0;
    case (src_q)
      SRC_MEM:  rdata_mux = mem_rd_q;
      SRC_FILL: rdata_mux = FILL_WORD;
      default:  rdata_mux = '0;
    endcase
  end

  assign bus.rdata    = rdata_mux;
  assign bus.addr_err = addr_err_q;
  assign mem_ready    = mem_ready_q;

endmodule

// File: doc/inst_sram_resp.md
# inst_sram_resp

Synchronous single-port instruction-memory responder serving the fetch stage's `inst_sram_*` initiator interface. It returns the word addressed in cycle N on `inst_sram_rdata` in cycle N+1 and holds that data while `inst_sram_en` is low, which is what the fetch stage relies on to stall a PC in place. It accepts byte-masked writes and flags accesses outside its window. It sits at the top level between the CPU core and the instruction address space.

## Interface
- `ADDR_WIDTH`, 12: word-index width; depth = 2^ADDR_WIDTH words.
- `BASE_ADDR`, 32'h1c00_0000: byte address of word 0; must be 4-byte aligned.
- `FILL_WORD`, 32'h0340_0000: value written by the clear sweep (LoongArch `nop`).

Ports:
- `clk` in 1: the only clock.
- `resetn` in 1: synchronous, active-low reset.
- `inst_sram_en` in 1: access enable for this cycle.
- `inst_sram_we` in 4: byte write enables; 0 = read.
- `inst_sram_addr` in 32: byte address; bits [1:0] ignored.
- `inst_sram_wdata` in 32: write data, byte lanes per `we`.
- `inst_sram_rdata` out 32: registered read data.
- `mem_ready` out 1: memory is in RUN state.
- `addr_err` out 1: registered; the previous enabled access was out of window.

## Operation
- Offset = `inst_sram_addr` − `BASE_ADDR`, computed as a 32-bit unsigned subtraction that wraps modulo 2^32.
- The access is in range iff offset < 4·2^ADDR_WIDTH, unsigned. Addresses below `BASE_ADDR` therefore wrap to a large offset and are out of range.
- Word index = offset[ADDR_WIDTH+1:2].
- State machine: CLEAR → RUN. Without `INST_SRAM_CLEAR_EN`, reset enters RUN directly.
- RUN, `en`=1, in range:
  - `rdata` ← mem[index] as it was before this cycle's write (read-first).
  - For each lane i with we[i]=1, mem[index] byte i ← wdata byte i.
  - `addr_err` ← 0.
- RUN, `en`=1, out of range:
  - `rdata` ← 0; any write is dropped.
  - `addr_err` ← 1.
- `en`=0, in any state: `rdata` and `addr_err` hold; memory is unchanged.
- CLEAR state: see Configuration. In CLEAR, enabled accesses return `FILL_WORD`, set `addr_err` ← 0, and drop their writes.
- `mem_ready` = (state == RUN), driven from a register.

## Timing
- Read latency: exactly 1 cycle from the `en`=1 edge to valid `rdata`.
- Fetch stage contract: the address presented in cycle N selects the instruction observed in cycle N+1; `rdata` stays stable for as long as `en` stays low.
- Same-address write followed by read: a read in the next cycle returns the newly written data.
- Reset values:
  - `rdata` = 0
  - `addr_err` = 0
  - `mem_ready` = 0 when `INST_SRAM_CLEAR_EN` is defined, otherwise 1 from the first cycle after reset
  - clear counter = 0
- Memory contents are not reset (except by the clear sweep).
- Reset asserted mid-operation, in any state: outputs return to their reset values on that edge. A CLEAR sweep restarts from index 0.
- No back-pressure exists. Every enabled request completes in one cycle.

## Configuration
- Macro `INST_SRAM_CLEAR_EN`.
- Defined:
  - After reset the block is in CLEAR and writes `FILL_WORD` to index k at cycle k, for k = 0 .. 2^ADDR_WIDTH−1.
  - On the cycle after the write to the last index, the state becomes RUN and `mem_ready` rises.
  - Total: 2^ADDR_WIDTH cycles, then RUN.
  - The top level must hold the core in reset until `mem_ready` = 1.
- Undefined:
  - No CLEAR state and no clear counter.
  - RUN from the first cycle after reset; `mem_ready` is tied high after reset.
  - Memory starts with its initial-file or unknown contents.

## Test plan
- Reset, then `en`=1, addr 32'h1c00_0000, preloaded word 32'h1234_5678 → next cycle `rdata`=32'h1234_5678, `addr_err`=0.
- Read 32'h1c00_0004 (value A), then hold `en`=0 for 3 cycles → `rdata`=A throughout.
- Write we=4'b0101, wdata=32'hAABB_CCDD to a word holding 32'h1111_1111, then read it back → the write cycle returns 32'h1111_1111, the readback returns 32'h11BB_11DD.
- Access 32'h1bff_fffc, then 32'h1c00_0000 + 4·2^ADDR_WIDTH (write we=4'hF) → each returns `rdata`=0 and `addr_err`=1. The word at index 0 is unchanged.
- With `INST_SRAM_CLEAR_EN` and ADDR_WIDTH=4:
  - `mem_ready` rises exactly 16 cycles after reset release; every word then reads 32'h0340_0000.
  - Pulse `resetn` low at cycle 8 → `mem_ready`=0 and the sweep restarts, so 16 further cycles are needed.
- Reads issued during CLEAR → `rdata`=FILL_WORD; a write issued during CLEAR has no effect after RUN.
